// File: rtl/reg_wb_queue_pkg.sv
// Shared defaults and entry type for the register writeback queue.
// Forwarding is compiled in only when REG_WB_BYPASS_EN is defined.
package reg_wb_queue_pkg;

   localparam int REG_WB_DATA_W = 16;
   localparam int REG_WB_ADDR_W = 3;
   localparam int REG_WB_DEPTH  = 4;

   typedef struct packed {
      logic [REG_WB_ADDR_W-1:0] addr;
      logic [REG_WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_wb_fwd_match.sv
// Youngest-match search over the occupied queue slots for one read port.
module reg_wb_fwd_match
   import reg_wb_queue_pkg::*;
#(
   parameter int DEPTH  = REG_WB_DEPTH,
   parameter int DATA_W = REG_WB_DATA_W,
   parameter int ADDR_W = REG_WB_ADDR_W
) (
   input  logic [$clog2(DEPTH)-1:0] rd_ptr,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic [ADDR_W-1:0]        entry_addr [DEPTH],
   input  logic [DATA_W-1:0]        entry_data [DEPTH],
   input  logic [ADDR_W-1:0]        read_addr,
   input  logic [DATA_W-1:0]        read_data,
   output logic [DATA_W-1:0]        fwd_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] slot;

   // Walk oldest to youngest so the last hit (youngest) wins.
   always_comb begin
      fwd_data = read_data;
      slot     = '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
         slot = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (entry_addr[slot] == read_addr)) begin
            fwd_data = entry_data[slot];
         end
      end
   end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order writeback queue draining into the register file, with optional
// read forwarding of pending writes (define REG_WB_BYPASS_EN to enable).
module reg_wb_queue
   import reg_wb_queue_pkg::*;
#(
   parameter int DEPTH  = REG_WB_DEPTH,
   parameter int DATA_W = REG_WB_DATA_W,
   parameter int ADDR_W = REG_WB_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     wb_hold,
   output logic                     reg_write_en,
   output logic [ADDR_W-1:0]        reg_write_addr,
   output logic [DATA_W-1:0]        reg_write_data,
   input  logic [ADDR_W-1:0]        reg_read_addr1,
   input  logic [ADDR_W-1:0]        reg_read_addr2,
   input  logic [DATA_W-1:0]        reg_read_data1,
   input  logic [DATA_W-1:0]        reg_read_data2,
   output logic [DATA_W-1:0]        fwd_read_data1,
   output logic [DATA_W-1:0]        fwd_read_data2,
   output logic [$clog2(DEPTH):0]   pending_cnt,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   assign empty          = (count == '0);
   assign pending_cnt    = count;
   assign reg_write_en   = !rst && !empty && !wb_hold;
   assign wb_ready       = !rst && ((count < CNT_W'(DEPTH)) || reg_write_en);
   assign push           = wb_valid && wb_ready;
   assign pop            = reg_write_en;
   assign reg_write_addr = empty ? '0 : mem_addr[rd_ptr];
   assign reg_write_data = empty ? '0 : mem_data[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is never reset; occupancy is tracked solely by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= wb_addr;
         mem_data[wr_ptr] <= wb_data;
      end
   end

`ifdef REG_WB_BYPASS_EN
   reg_wb_fwd_match #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_fwd1 (
      .rd_ptr    (rd_ptr),
      .count     (count),
      .entry_addr(mem_addr),
      .entry_data(mem_data),
      .read_addr (reg_read_addr1),
      .read_data (reg_read_data1),
      .fwd_data  (fwd_read_data1)
   );

   reg_wb_fwd_match #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_fwd2 (
      .rd_ptr    (rd_ptr),
      .count     (count),
      .entry_addr(mem_addr),
      .entry_data(mem_data),
      .read_addr (reg_read_addr2),
      .read_data (reg_read_data2),
      .fwd_data  (fwd_read_data2)
   );
`else
   assign fwd_read_data1 = reg_read_data1;
   assign fwd_read_data2 = reg_read_data2;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed table, wrap sequence,
// and randomized traffic against a queue-based reference model.
module tb_reg_wb_queue;
   import reg_wb_queue_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_hold;
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_write_addr;
   logic [DATA_W-1:0] reg_write_data;
   logic [ADDR_W-1:0] reg_read_addr1, reg_read_addr2;
   logic [DATA_W-1:0] reg_read_data1, reg_read_data2;
   logic [DATA_W-1:0] fwd_read_data1, fwd_read_data2;
   logic [2:0]        pending_cnt;
   logic              empty;

   reg_wb_queue #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .wb_hold       (wb_hold),
      .reg_write_en  (reg_write_en),
      .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data),
      .reg_read_addr1(reg_read_addr1),
      .reg_read_addr2(reg_read_addr2),
      .reg_read_data1(reg_read_data1),
      .reg_read_data2(reg_read_data2),
      .fwd_read_data1(fwd_read_data1),
      .fwd_read_data2(fwd_read_data2),
      .pending_cnt   (pending_cnt),
      .empty         (empty)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   wb_entry_t q[$];      // reference model contents, oldest first
   wb_entry_t wlog[$];   // writes observed at the register file port
   wb_entry_t plog[$];   // pushes accepted, in order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_we();
      return !rst && (q.size() > 0) && !wb_hold;
   endfunction

   function automatic bit m_ready();
      return !rst && ((q.size() < DEPTH) || m_we());
   endfunction

   function automatic logic [DATA_W-1:0] m_fwd(input logic [ADDR_W-1:0] ra,
                                              input logic [DATA_W-1:0] rd);
      logic [DATA_W-1:0] r;
      r = rd;
`ifdef REG_WB_BYPASS_EN
      foreach (q[i]) if (q[i].addr == ra) r = q[i].data;
`endif
      return r;
   endfunction

   task automatic check_model();
      chk("rand_we",    32'(reg_write_en),   32'(m_we()));
      chk("rand_ready", 32'(wb_ready),       32'(m_ready()));
      chk("rand_cnt",   32'(pending_cnt),    32'(q.size()));
      chk("rand_empty", 32'(empty),          32'(q.size() == 0));
      chk("rand_waddr", 32'(reg_write_addr), (q.size() > 0) ? 32'(q[0].addr) : 32'd0);
      chk("rand_wdata", 32'(reg_write_data), (q.size() > 0) ? 32'(q[0].data) : 32'd0);
      chk("rand_fwd1",  32'(fwd_read_data1), 32'(m_fwd(reg_read_addr1, reg_read_data1)));
      chk("rand_fwd2",  32'(fwd_read_data2), 32'(m_fwd(reg_read_addr2, reg_read_data2)));
   endtask

   // Inputs are driven 1 time unit after the edge; checks happen 1 later.
   task automatic tick(input bit use_model);
      bit pop, push, r;
      wb_entry_t e;
      #1;
      if (use_model) check_model();
      if (reg_write_en) begin
         e.addr = reg_write_addr;
         e.data = reg_write_data;
         wlog.push_back(e);
      end
      pop  = m_we();
      push = wb_valid && m_ready();
      r    = rst;
      e.addr = wb_addr;
      e.data = wb_data;
      @(posedge clk);
      if (r) q.delete();
      else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(e);
      end
      #1;
   endtask

   typedef struct {
      bit                r, v, h;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      bit                we;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
      int                cnt;
      bit                rdy;
      logic [DATA_W-1:0] f_on, f_off;
   } vec_t;

   function automatic vec_t mk(bit r, bit v, bit h, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                               logic [ADDR_W-1:0] ra, logic [DATA_W-1:0] rd, bit we,
                               logic [ADDR_W-1:0] wa, logic [DATA_W-1:0] wd, int cnt, bit rdy,
                               logic [DATA_W-1:0] f_on, logic [DATA_W-1:0] f_off);
      vec_t t;
      t.r = r; t.v = v; t.h = h; t.a = a; t.d = d; t.ra = ra; t.rd = rd;
      t.we = we; t.wa = wa; t.wd = wd; t.cnt = cnt; t.rdy = rdy; t.f_on = f_on; t.f_off = f_off;
      return t;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [DATA_W-1:0] fexp;
      int issued;
      int cyc;

      rst = 1'b1; wb_valid = 1'b0; wb_hold = 1'b0; wb_addr = '0; wb_data = '0;
      reg_read_addr1 = '0; reg_read_addr2 = '0; reg_read_data1 = '0; reg_read_data2 = '0;
      repeat (2) @(posedge clk);
      #1;
      q.delete();

      //           r v h a  d        ra rd       we wa wd      cnt rdy f_on     f_off
      vecs.push_back(mk(1,0,0,0,16'h0000, 3,16'h5555, 0,0,16'h0000,0,0, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,0,3,16'h1234, 3,16'h5555, 0,0,16'h0000,0,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 3,16'h5555, 1,3,16'h1234,1,1, 16'h1234,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 3,16'h5555, 0,0,16'h0000,0,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,1,1,16'hAAAA, 7,16'h5555, 0,0,16'h0000,0,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,1,2,16'hBBBB, 7,16'h5555, 0,1,16'hAAAA,1,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,1,3,16'hCCCC, 7,16'h5555, 0,1,16'hAAAA,2,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,1,4,16'hDDDD, 7,16'h5555, 0,1,16'hAAAA,3,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,1,6,16'h6666, 7,16'h5555, 0,1,16'hAAAA,4,0, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,0,6,16'h6666, 7,16'h5555, 1,1,16'hAAAA,4,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 7,16'h5555, 1,2,16'hBBBB,4,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 7,16'h5555, 1,3,16'hCCCC,3,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 7,16'h5555, 1,4,16'hDDDD,2,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 7,16'h5555, 1,6,16'h6666,1,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,0,0,0,16'h0000, 7,16'h5555, 0,0,16'h0000,0,1, 16'h5555,16'h5555));
      vecs.push_back(mk(0,1,1,5,16'h0001, 5,16'hFFFF, 0,0,16'h0000,0,1, 16'hFFFF,16'hFFFF));
      vecs.push_back(mk(0,1,1,5,16'h0002, 5,16'hFFFF, 0,5,16'h0001,1,1, 16'h0001,16'hFFFF));
      vecs.push_back(mk(0,1,1,2,16'h0BAD, 5,16'hFFFF, 0,5,16'h0001,2,1, 16'h0002,16'hFFFF));
      vecs.push_back(mk(1,1,0,0,16'h0000, 5,16'hFFFF, 0,5,16'h0001,3,0, 16'h0002,16'hFFFF));
      vecs.push_back(mk(0,0,0,0,16'h0000, 5,16'hFFFF, 0,0,16'h0000,0,1, 16'hFFFF,16'hFFFF));
      vecs.push_back(mk(0,0,0,0,16'h0000, 5,16'hFFFF, 0,0,16'h0000,0,1, 16'hFFFF,16'hFFFF));

      foreach (vecs[i]) begin
         rst = vecs[i].r; wb_valid = vecs[i].v; wb_hold = vecs[i].h;
         wb_addr = vecs[i].a; wb_data = vecs[i].d;
         reg_read_addr1 = vecs[i].ra; reg_read_data1 = vecs[i].rd;
         #1;
`ifdef REG_WB_BYPASS_EN
         fexp = vecs[i].f_on;
`else
         fexp = vecs[i].f_off;
`endif
         chk($sformatf("vec%0d_we", i),    32'(reg_write_en),   32'(vecs[i].we));
         chk($sformatf("vec%0d_waddr", i), 32'(reg_write_addr), 32'(vecs[i].wa));
         chk($sformatf("vec%0d_wdata", i), 32'(reg_write_data), 32'(vecs[i].wd));
         chk($sformatf("vec%0d_cnt", i),   32'(pending_cnt),    32'(vecs[i].cnt));
         chk($sformatf("vec%0d_empty", i), 32'(empty),          32'(vecs[i].cnt == 0));
         chk($sformatf("vec%0d_ready", i), 32'(wb_ready),       32'(vecs[i].rdy));
         chk($sformatf("vec%0d_fwd1", i),  32'(fwd_read_data1), 32'(fexp));
         tick(1'b0);
      end

      // Ten pushes with intermittent hold, wrapping the pointers twice.
      rst = 1'b1; wb_valid = 1'b0; wb_hold = 1'b0;
      tick(1'b0);
      rst = 1'b0;
      wlog.delete(); plog.delete();
      issued = 0;
      cyc = 0;
      while ((issued < 10 || q.size() > 0) && cyc < 80) begin
         wb_valid = (issued < 10);
         wb_hold  = (cyc % 3 == 1) || (cyc % 7 == 2);
         wb_addr  = ADDR_W'($urandom);
         wb_data  = DATA_W'($urandom);
         #1;
         if (wb_valid && m_ready()) begin
            plog.push_back('{addr: wb_addr, data: wb_data});
            issued++;
         end
         tick(1'b1);
         cyc++;
      end
      wb_valid = 1'b0;
      chk("wrap_count", 32'(wlog.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("wrap_write%0d", i),
             (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(plog[i]));
      end

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         rst            = ($urandom_range(0, 49) == 0);
         wb_valid       = ($urandom_range(0, 2) != 0);
         wb_hold        = ($urandom_range(0, 3) == 0);
         wb_addr        = ADDR_W'($urandom);
         wb_data        = DATA_W'($urandom);
         reg_read_addr1 = ADDR_W'($urandom);
         reg_read_addr2 = ADDR_W'($urandom);
         reg_read_data1 = DATA_W'($urandom);
         reg_read_data2 = DATA_W'($urandom);
         tick(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 Parameter DATA_W, default 16, register data width.
REQ-003 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wb_valid  in  1  writeback request present.
REQ-007 wb_ready  out  1  queue can accept a request this cycle.
REQ-008 wb_addr  in  ADDR_W  destination register of the request.
REQ-009 wb_data  in  DATA_W  result to write.
REQ-010 wb_hold  in  1  pauses draining into the register file.
REQ-011 reg_write_en  out  1  register file write strobe.
REQ-012 reg_write_addr  out  ADDR_W  register file write address.
REQ-013 reg_write_data  out  DATA_W  register file write data.
REQ-014 reg_read_addr1, reg_read_addr2  in  ADDR_W each  decode-stage read addresses, shared with the register file.
REQ-015 reg_read_data1, reg_read_data2  in  DATA_W each  raw register file read data.
REQ-016 fwd_read_data1, fwd_read_data2  out  DATA_W each  read data corrected for pending writes.
REQ-017 pending_cnt  out  $clog2(DEPTH)+1  number of queued entries.
REQ-018 empty  out  1  pending_cnt == 0.

Function
REQ-019 The queue SHALL be an in-order FIFO of {addr, data} entries with read pointer, write pointer and count.
REQ-020 Push SHALL occur on a posedge where wb_valid && wb_ready.
REQ-021 The queue SHALL set reg_write_en = !empty && !wb_hold combinationally, with reg_write_addr and reg_write_data driven from the head entry.
REQ-022 Pop SHALL occur on every posedge where reg_write_en is 1.
REQ-023 Latency: an entry pushed at edge N SHALL be written to the register file no earlier than edge N+1.
REQ-024 The queue SHALL set wb_ready = (pending_cnt < DEPTH) || reg_write_en, so a full queue accepts a push in the same cycle as a pop.
REQ-025 Simultaneous push and pop SHALL leave pending_cnt unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 Push while full with no pop SHALL be impossible, because wb_ready is 0 in that case.
REQ-028 When no queued entry holds reg_read_addr1, fwd_read_data1 SHALL equal reg_read_data1.
REQ-029 When one or more queued entries hold reg_read_addr1, fwd_read_data1 SHALL equal the data of the youngest such entry; fwd_read_data2 SHALL follow the same rule with reg_read_addr2.
REQ-030 Forwarding SHALL consider stored entries only, including the head being written this cycle, and never the wb_data presented in the same cycle.
REQ-031 Forwarding outputs SHALL be combinational, with zero cycles of latency.
REQ-032 When the queue is empty, reg_write_addr and reg_write_data SHALL be 0.

Reset
REQ-033 On a posedge with rst=1, the queue SHALL set the pointers and count to 0 and discard all pending entries.
REQ-034 With rst=1, reg_write_en SHALL be 0 and wb_ready SHALL be 0.
REQ-035 After reset, while the queue is empty: empty=1, pending_cnt=0, reg_write_en=0, and fwd_read_dataN = reg_read_dataN.
REQ-036 A reset during draining SHALL drop the remaining entries; none SHALL be written afterwards.
REQ-037 Entry storage SHALL NOT require reset.

Configuration
REQ-038 Macro REG_WB_BYPASS_EN SHALL compile in the forwarding comparators and priority selection of REQ-028..REQ-031.
REQ-039 Without REG_WB_BYPASS_EN, fwd_read_dataN SHALL equal reg_read_dataN unconditionally; all other behaviour is unchanged.

Structure
REQ-040 A shared package SHALL hold DATA_W and ADDR_W defaults and the wb_entry_t typedef {addr, data}.
REQ-041 A sub-module reg_wb_fwd_match SHALL implement the per-port youngest-match search, instantiated once per read port, and only when REG_WB_BYPASS_EN is defined.

Verification
REQ-042 Test: after reset, push {3, 0x1234} with wb_hold=0 -> next cycle reg_write_en=1, addr=3, data=0x1234; the cycle after, empty=1.
REQ-043 Test: hold=1, push {1,0xAAAA}, {2,0xBBBB}, {3,0xCCCC}, {4,0xDDDD} -> pending_cnt=4, wb_ready=0; release hold -> writes occur on 4 consecutive cycles in push order.
REQ-044 Test: full queue, hold=0, wb_valid=1 -> wb_ready=1; push and pop in the same cycle leave pending_cnt at 4.
REQ-045 Test: hold=1, push {5,0x0001} then {5,0x0002}, reg_read_addr1=5, reg_read_data1=0xFFFF -> fwd_read_data1=0x0002 with macro defined, 0xFFFF without.
REQ-046 Test: 3 entries pending, assert rst for one cycle -> pending_cnt=0; no reg_write_en pulse follows.
REQ-047 Test: push 10 entries with intermittent hold to exercise pointer wrap -> write sequence exactly matches push sequence.
